// File: rtl/display_pkg.sv
// Shared types and constants for the note-display sequencer: FSM state
// encoding, datapath counter widths and default timing parameters.
package display_pkg;

  localparam int GRID_W = 14;
  localparam int BOX_W  = 4;
  localparam int PIX_W  = 16;

  localparam int DEF_GRID_ENTRIES = 8192;
  localparam int DEF_NUM_BOXES    = 3;
  localparam int DEF_BOX_PIXELS   = 1600;
  localparam int DEF_BEAT_CYCLES  = 12500000;
  localparam int DEF_MEM_LAT      = 2;

  typedef enum logic [3:0] {
    ST_DEF_ADDR,
    ST_DEF_WAIT,
    ST_DEF_LOAD,
    ST_DEF_WR,
    ST_IDLE,
    ST_SHIFT,
    ST_BOX_ADDR,
    ST_BOX_WAIT,
    ST_BOX_LOAD,
    ST_PIX_WAIT,
    ST_PIX_LX,
    ST_PIX_LY,
    ST_PIX_WR
  } state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_sequencer_beat_timer.sv
// Beat timer: free-running cycle counter that emits a tick on wrap and
// keeps a one-deep queue of pending beats plus a sticky overrun flag.
module beat_timer
  import display_pkg::*;
#(
  parameter int BEAT_CYCLES = DEF_BEAT_CYCLES
) (
  input  logic clock,
  input  logic resetn,
  input  logic enable,
  input  logic clr_pending,
  output logic pending,
  output logic beat_overrun
);

  localparam int CNT_W = cnt_width(BEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BEAT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic             tick;

  // Next-state: counter freezes with enable low; a tick consumed in the same
  // cycle as the FSM clears pending simply re-arms the queue.
  always_comb begin
    tick      = enable && (cnt_q == CNT_MAX);
    cnt_d     = cnt_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
    if (clr_pending) begin
      pending_d = 1'b0;
    end
    if (tick) begin
      if (pending_q && !clr_pending) begin
        overrun_d = 1'b1;
      end
      pending_d = 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending      = pending_q;
  assign beat_overrun = overrun_q;

endmodule

// File: rtl/display_sequencer.sv
// Note-display sequencer: paints the default background after reset, then
// on every beat shifts the song and redraws each note box pixel by pixel.
// All strobes and counters are registered and change only on clock edges.
module display_sequencer
  import display_pkg::*;
#(
  parameter int GRID_ENTRIES = DEF_GRID_ENTRIES,
  parameter int NUM_BOXES    = DEF_NUM_BOXES,
  parameter int BOX_PIXELS   = DEF_BOX_PIXELS,
  parameter int BEAT_CYCLES  = DEF_BEAT_CYCLES,
  parameter int MEM_LAT      = DEF_MEM_LAT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              enable,
  output logic              shiftSong,
  output logic              loadStartAddress,
  output logic              loadX,
  output logic              loadY,
  output logic              loadDefault,
  output logic              writeDefault,
  output logic              writeToScreen,
  output logic [GRID_W-1:0] gridCounter,
  output logic [BOX_W-1:0]  boxCounter,
  output logic [PIX_W-1:0]  pixelCount,
  output logic              plot,
  output logic              busy,
  output logic              beat_overrun
);

  localparam int WAIT_W = cnt_width(MEM_LAT);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_LAT - 1);
  localparam logic [GRID_W-1:0] LAST_GRID = GRID_W'(GRID_ENTRIES - 1);
  localparam logic [BOX_W-1:0]  LAST_BOX  = BOX_W'(NUM_BOXES - 1);
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(BOX_PIXELS - 1);

  state_e            state_q;
  logic [WAIT_W-1:0] wait_q;
  logic [GRID_W-1:0] grid_q;
  logic [BOX_W-1:0]  box_q;
  logic [PIX_W-1:0]  pix_q;
  logic              shift_q, lsa_q, lx_q, ly_q, ld_q, wdef_q, wts_q;
  logic              plot_q, busy_q;
  logic              pending;
  logic              clr_pending;

  // A pending beat is consumed exactly when the FSM leaves IDLE.
  assign clr_pending = (state_q == ST_IDLE) && pending && enable;

  beat_timer #(
    .BEAT_CYCLES (BEAT_CYCLES)
  ) u_beat_timer (
    .clock        (clock),
    .resetn       (resetn),
    .enable       (enable),
    .clr_pending  (clr_pending),
    .pending      (pending),
    .beat_overrun (beat_overrun)
  );

  // Sequencer FSM; each strobe is set on the edge that enters its state so
  // every output comes straight from a flop.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      state_q <= ST_DEF_ADDR;
      wait_q  <= '0;
      grid_q  <= '0;
      box_q   <= '0;
      pix_q   <= '0;
      shift_q <= 1'b0;
      lsa_q   <= 1'b0;
      lx_q    <= 1'b0;
      ly_q    <= 1'b0;
      ld_q    <= 1'b0;
      wdef_q  <= 1'b0;
      wts_q   <= 1'b0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= 1'b0;
      lsa_q   <= 1'b0;
      lx_q    <= 1'b0;
      ly_q    <= 1'b0;
      ld_q    <= 1'b0;
      wdef_q  <= 1'b0;
      wts_q   <= 1'b0;
      // plot lines up with the datapath's registered VGA outputs
      plot_q  <= wts_q;
      case (state_q)
        ST_DEF_ADDR: begin
          state_q <= ST_DEF_WAIT;
          wait_q  <= '0;
          busy_q  <= 1'b1;
        end
        ST_DEF_WAIT: begin
          if (wait_q == LAST_WAIT) begin
            state_q <= ST_DEF_LOAD;
            ld_q    <= 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ST_DEF_LOAD: begin
          state_q <= ST_DEF_WR;
          wts_q   <= 1'b1;
          wdef_q  <= 1'b1;
        end
        ST_DEF_WR: begin
          if (grid_q == LAST_GRID) begin
            grid_q  <= '0;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            grid_q  <= grid_q + GRID_W'(1);
            state_q <= ST_DEF_ADDR;
          end
        end
        ST_IDLE: begin
          if (pending && enable) begin
            state_q <= ST_SHIFT;
            shift_q <= 1'b1;
            box_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          state_q <= ST_BOX_ADDR;
        end
        ST_BOX_ADDR: begin
          state_q <= ST_BOX_WAIT;
          wait_q  <= '0;
        end
        ST_BOX_WAIT: begin
          if (wait_q == LAST_WAIT) begin
            state_q <= ST_BOX_LOAD;
            lsa_q   <= 1'b1;
            pix_q   <= '0;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ST_BOX_LOAD: begin
          state_q <= ST_PIX_WAIT;
          wait_q  <= '0;
        end
        ST_PIX_WAIT: begin
          // ROM output plus the registered address sum need MEM_LAT cycles
          if (wait_q == LAST_WAIT) begin
            state_q <= ST_PIX_LX;
            lx_q    <= 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ST_PIX_LX: begin
          state_q <= ST_PIX_LY;
          ly_q    <= 1'b1;
        end
        ST_PIX_LY: begin
          state_q <= ST_PIX_WR;
          wts_q   <= 1'b1;
        end
        ST_PIX_WR: begin
          if (pix_q != LAST_PIX) begin
            pix_q   <= pix_q + PIX_W'(1);
            state_q <= ST_PIX_WAIT;
            wait_q  <= '0;
          end else if (box_q != LAST_BOX) begin
            box_q   <= box_q + BOX_W'(1);
            state_q <= ST_BOX_ADDR;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign shiftSong        = shift_q;
  assign loadStartAddress = lsa_q;
  assign loadX            = lx_q;
  assign loadY            = ly_q;
  assign loadDefault      = ld_q;
  assign writeDefault     = wdef_q;
  assign writeToScreen    = wts_q;
  assign gridCounter      = grid_q;
  assign boxCounter       = box_q;
  assign pixelCount       = pix_q;
  assign plot             = plot_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Directed bench for display_sequencer: default paint timing, beat-driven
// box redraw, enable gating, asynchronous reset and beat overrun.
module tb_display_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance: 50-cycle beat
  logic        rst, en;
  logic        shiftSong, lsa, lx, ly, ld, wdef, wts, plot, busy, ovr;
  logic [13:0] grid;
  logic [3:0]  boxc;
  logic [15:0] pix;
  logic [43:0] outs;
  assign outs = {shiftSong, lsa, lx, ly, ld, wdef, wts, plot, busy, ovr, grid, boxc, pix};

  // second instance: 8-cycle beat, shorter than one frame
  logic        rst2, en2;
  logic        shiftSong2, lsa2, lx2, ly2, ld2, wdef2, wts2, plot2, busy2, ovr2;
  logic [13:0] grid2;
  logic [3:0]  boxc2;
  logic [15:0] pix2;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  display_sequencer #(
    .GRID_ENTRIES(4), .NUM_BOXES(3), .BOX_PIXELS(2), .BEAT_CYCLES(50), .MEM_LAT(2)
  ) dut (
    .clock(clk), .resetn(rst), .enable(en),
    .shiftSong(shiftSong), .loadStartAddress(lsa), .loadX(lx), .loadY(ly),
    .loadDefault(ld), .writeDefault(wdef), .writeToScreen(wts),
    .gridCounter(grid), .boxCounter(boxc), .pixelCount(pix),
    .plot(plot), .busy(busy), .beat_overrun(ovr)
  );

  display_sequencer #(
    .GRID_ENTRIES(4), .NUM_BOXES(3), .BOX_PIXELS(2), .BEAT_CYCLES(8), .MEM_LAT(2)
  ) dut2 (
    .clock(clk), .resetn(rst2), .enable(en2),
    .shiftSong(shiftSong2), .loadStartAddress(lsa2), .loadX(lx2), .loadY(ly2),
    .loadDefault(ld2), .writeDefault(wdef2), .writeToScreen(wts2),
    .gridCounter(grid2), .boxCounter(boxc2), .pixelCount(pix2),
    .plot(plot2), .busy(busy2), .beat_overrun(ovr2)
  );

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    en   = 1'b1;
    rst2 = 1'b1;
    en2  = 1'b0;
    #3;
    checks++;
    if (outs !== 44'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    @(posedge clk);
    #1;
    checks++;
    if (outs !== 44'h0) begin
      errors++;
      $display("FAIL reset_held: got %h expected 0", outs);
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_default_paint;
    logic        e_ld, e_wts, e_busy;
    logic [13:0] e_grid;
    for (int c = 1; c <= 20; c++) begin
      step();
      e_ld   = (c == 3) || (c == 8) || (c == 13) || (c == 18);
      e_wts  = (c == 4) || (c == 9) || (c == 14) || (c == 19);
      e_busy = (c < 20);
      checks++;
      if ({ld, wts, wdef, busy} !== {e_ld, e_wts, e_wts, e_busy}) begin
        errors++;
        $display("FAIL paint_strobes cycle %0d: ld/wts/wdef/busy got %b expected %b",
                 c, {ld, wts, wdef, busy}, {e_ld, e_wts, e_wts, e_busy});
      end
      if (e_ld || e_wts) begin
        e_grid = 14'((c - 3) / 5);
        checks++;
        if (grid !== e_grid) begin
          errors++;
          $display("FAIL paint_grid cycle %0d: got %0d expected %0d", c, grid, e_grid);
        end
      end
    end
    checks++;
    if (grid !== 14'd0) begin
      errors++;
      $display("FAIL paint_grid_wrap: got %0d expected 0", grid);
    end
  endtask

  task automatic test_first_beat;
    logic        p_wts, p_lx, p_ly;
    logic [15:0] p_pix;
    int          n_shift, shift_cyc, n_lsa, n_wts;
    p_wts = wts; p_lx = lx; p_ly = ly; p_pix = pix;
    n_shift = 0; shift_cyc = -1; n_lsa = 0; n_wts = 0;
    while (cyc < 100) begin
      step();
      checks++;
      if (plot !== p_wts) begin
        errors++;
        $display("FAIL plot_delay cycle %0d: got %b expected %b", cyc, plot, p_wts);
      end
      checks++;
      if ($countones({shiftSong, lsa, lx, ly, ld, wts}) > 1 || (wdef && !wts)) begin
        errors++;
        $display("FAIL strobe_exclusive cycle %0d: got %b expected at most one",
                 cyc, {shiftSong, lsa, lx, ly, ld, wts, wdef});
      end
      if (shiftSong) begin
        n_shift++;
        shift_cyc = cyc;
      end
      if (lsa) begin
        checks++;
        if (boxc !== 4'(n_lsa) || pix !== 16'd0) begin
          errors++;
          $display("FAIL box_start: box %0d pix %0d expected box %0d pix 0", boxc, pix, n_lsa);
        end
        n_lsa++;
      end
      if (ly) begin
        checks++;
        if (p_lx !== 1'b1 || pix !== p_pix) begin
          errors++;
          $display("FAIL loady_order cycle %0d: prev loadX %b pix %0d expected 1 and %0d",
                   cyc, p_lx, pix, p_pix);
        end
      end
      if (wts) begin
        checks++;
        if (p_ly !== 1'b1 || wdef !== 1'b0 || pix !== p_pix || pix !== 16'(n_wts % 2)) begin
          errors++;
          $display("FAIL write_order cycle %0d: prev loadY %b wdef %b pix %0d expected 1 0 %0d",
                   cyc, p_ly, wdef, pix, n_wts % 2);
        end
        n_wts++;
      end
      if (cyc == 93 || cyc == 94) begin
        checks++;
        if (busy !== (cyc == 93)) begin
          errors++;
          $display("FAIL frame_end_busy cycle %0d: got %b expected %b", cyc, busy, cyc == 93);
        end
      end
      p_wts = wts; p_lx = lx; p_ly = ly; p_pix = pix;
    end
    checks++;
    if (n_shift != 1 || shift_cyc != 51) begin
      errors++;
      $display("FAIL shift_once: got %0d at cycle %0d expected 1 at cycle 51", n_shift, shift_cyc);
    end
    checks++;
    if (n_lsa != 3) begin
      errors++;
      $display("FAIL box_count: got %0d expected 3", n_lsa);
    end
    checks++;
    if (n_wts != 6) begin
      errors++;
      $display("FAIL pixel_writes: got %0d expected 6", n_wts);
    end
  endtask

  task automatic test_enable_drop;
    int shift_cyc, n_lsa2, n_shift, n_busy, start;
    shift_cyc = -1;
    while (cyc < 120) begin
      step();
      if (shiftSong && shift_cyc < 0) shift_cyc = cyc;
    end
    checks++;
    if (shift_cyc != 101) begin
      errors++;
      $display("FAIL second_beat: got cycle %0d expected 101", shift_cyc);
    end
    en = 1'b0;
    n_lsa2 = 0;
    while (cyc < 143) begin
      step();
      if (lsa) begin
        checks++;
        if (boxc !== 4'd2) begin
          errors++;
          $display("FAIL drop_box: got %0d expected 2", boxc);
        end
        n_lsa2++;
      end
    end
    checks++;
    if (busy !== 1'b1 || n_lsa2 != 1) begin
      errors++;
      $display("FAIL drop_finish: busy %b boxes %0d expected 1 and 1", busy, n_lsa2);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: got %b expected 0", busy);
    end
    n_shift = 0;
    n_busy  = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (shiftSong) n_shift++;
      if (busy) n_busy++;
    end
    checks++;
    if (n_shift != 0 || n_busy != 0) begin
      errors++;
      $display("FAIL drop_hold: shifts %0d busy cycles %0d expected 0 and 0", n_shift, n_busy);
    end
    en = 1'b1;
    start = cyc;
    shift_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (shiftSong && shift_cyc < 0) shift_cyc = cyc - start;
    end
    checks++;
    if (shift_cyc != 31) begin
      errors++;
      $display("FAIL resume_beat: got offset %0d expected 31", shift_cyc);
    end
  endtask

  task automatic test_reset_midpaint;
    // abort an in-flight frame first
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== 44'h0) begin
      errors++;
      $display("FAIL abort_frame: got %h expected 0", outs);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    while (cyc < 13) step();
    checks++;
    if (ld !== 1'b1 || grid !== 14'd2) begin
      errors++;
      $display("FAIL midpaint_setup: ld %b grid %0d expected 1 and 2", ld, grid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== 44'h0) begin
      errors++;
      $display("FAIL midpaint_async: got %h expected 0", outs);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if (ld !== (c == 3) || grid !== 14'd0) begin
        errors++;
        $display("FAIL repaint cycle %0d: ld %b grid %0d expected %b and 0", c, ld, grid, c == 3);
      end
    end
  endtask

  task automatic test_overrun;
    int n_shift, s0, s1;
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    en2  = 1'b0;
    cyc  = 0;
    while (cyc < 20) step();
    checks++;
    if (busy2 !== 1'b0 || ovr2 !== 1'b0) begin
      errors++;
      $display("FAIL ovr_paint_done: busy %b overrun %b expected 0 0", busy2, ovr2);
    end
    en2 = 1'b1;
    n_shift = 0; s0 = -1; s1 = -1;
    while (cyc < 200) begin
      step();
      if (shiftSong2) begin
        if (n_shift == 0) s0 = cyc;
        if (n_shift == 1) s1 = cyc;
        n_shift++;
      end
      if (cyc == 43 || cyc == 44) begin
        checks++;
        if (ovr2 !== (cyc == 44)) begin
          errors++;
          $display("FAIL overrun_set cycle %0d: got %b expected %b", cyc, ovr2, cyc == 44);
        end
      end
      if (cyc == 72) begin
        checks++;
        if (busy2 !== 1'b0) begin
          errors++;
          $display("FAIL frame_gap: got busy %b expected 0", busy2);
        end
      end
      if (cyc == 73) en2 = 1'b0;
      if (cyc == 116) begin
        checks++;
        if (busy2 !== 1'b0) begin
          errors++;
          $display("FAIL second_frame_end: got busy %b expected 0", busy2);
        end
      end
    end
    checks++;
    if (n_shift != 2 || s0 != 29 || s1 != 73) begin
      errors++;
      $display("FAIL two_frames: got %0d shifts at %0d,%0d expected 2 at 29,73", n_shift, s0, s1);
    end
    checks++;
    if (ovr2 !== 1'b1 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL overrun_sticky: overrun %b busy %b expected 1 0", ovr2, busy2);
    end
  endtask

  initial begin
    test_reset();
    test_default_paint();
    test_first_beat();
    test_enable_drop();
    test_reset_midpaint();
    test_overrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/display_sequencer.md
Name: display_sequencer

Overview:
- FSM that sequences the note-display datapath. After reset it paints the default background image entry-by-entry.
- It then waits for a beat tick. On each tick it shifts the song registers and redraws every note box pixel-by-pixel.
- It drives all datapath strobes and counters (shiftSong, loadStartAddress, loadX/loadY, loadDefault, writeDefault, writeToScreen, gridCounter, boxCounter, pixelCount), plus the VGA adapter plot enable.

Parameters:
- GRID_ENTRIES, 8192: number of default-image ROM entries painted after reset.
- NUM_BOXES, 3: note boxes redrawn per beat; boxCounter runs 0..NUM_BOXES-1.
- BOX_PIXELS, 1600: pixels per box; pixelCount runs 0..BOX_PIXELS-1.
- BEAT_CYCLES, 12500000: clock cycles per beat tick (4 Hz at 50 MHz).
- MEM_LAT, 2: wait cycles between address change and valid ROM/sum data.

Ports:
- clock  in  1  system clock; all logic rising-edge.
- resetn  in  1  asynchronous, active-high reset. Despite the name, 1 = reset.
- enable  in  1  1 = beats advance; 0 = finish current frame, then hold in IDLE.
- shiftSong  out  1  one-cycle pulse; rotates the song registers.
- loadStartAddress  out  1  one-cycle pulse; latches the box start address.
- loadX  out  1  one-cycle pulse; latches X from the current address.
- loadY  out  1  one-cycle pulse; latches Y from the current address.
- loadDefault  out  1  one-cycle pulse; latches the default-image entry.
- writeDefault  out  1  high with writeToScreen while painting the default image.
- writeToScreen  out  1  one-cycle pulse; datapath registers VGA x/y/colour.
- gridCounter  out  14  default-image ROM index.
- boxCounter  out  4  current box index.
- pixelCount  out  16  pixel offset within the current box.
- plot  out  1  VGA write enable, asserted the cycle after writeToScreen.
- busy  out  1  high in every state except IDLE.
- beat_overrun  out  1  sticky; set when a tick arrives while one is already pending. Cleared only by reset.

Behaviour:
- Reset (async, resetn=1): state=DEF_ADDR, every output=0, beat counter=0, pending=0.
- Beat timer: free-running counter 0..BEAT_CYCLES-1, advancing only while enable=1.
  - On wrap it produces a one-cycle tick.
  - Tick with pending=0 sets pending. Tick with pending=1 sets beat_overrun; pending stays 1 (one-deep queue).
- Default paint (per entry):
  - DEF_ADDR: gridCounter holds its value.
  - DEF_WAIT: MEM_LAT cycles.
  - DEF_LOAD: loadDefault=1.
  - DEF_WR: writeToScreen=1 and writeDefault=1.
  - Then gridCounter++ and return to DEF_ADDR. After gridCounter=GRID_ENTRIES-1, reset gridCounter to 0 and go to IDLE.
  - Per entry: MEM_LAT+3 cycles.
- IDLE: busy=0. Go to SHIFT when pending=1 and enable=1, clearing pending in the same cycle. A tick arriving in that same cycle re-sets pending.
- SHIFT: shiftSong=1 for 1 cycle, boxCounter=0 → BOX_ADDR.
- Box redraw:
  - BOX_ADDR, then BOX_WAIT for MEM_LAT cycles.
  - BOX_LOAD: loadStartAddress=1, pixelCount=0.
  - Per pixel: PIX_WAIT (MEM_LAT cycles, for ROM output plus registered sum), PIX_LX (loadX=1), PIX_LY (loadY=1), PIX_WR (writeToScreen=1).
  - After PIX_WR: if pixelCount<BOX_PIXELS-1, increment it and go to PIX_WAIT. Otherwise, if boxCounter<NUM_BOXES-1, increment boxCounter and go to BOX_ADDR; else go to IDLE.
  - Per pixel: MEM_LAT+3 cycles.
- plot = writeToScreen delayed one register stage, so it aligns with the registered vgaOut* of the datapath.
- Strobes are mutually exclusive, except writeDefault together with writeToScreen. All are registered outputs and glitch-free.
- pixelCount and boxCounter are only ever written by the FSM and never exceed their parameter bounds.
- enable deasserted mid-frame: the frame completes; then the FSM idles and the beat counter freezes.
- Reset mid-frame: immediate abort, and the default image is repainted.

Decomposition:
- Package display_pkg: state enum, counter widths (GRID_W=14, BOX_W=4, PIX_W=16), default parameter constants.
- Sub-module beat_timer: counter, tick, pending flag and overrun flag; ports clock, resetn, enable, clr_pending, pending, beat_overrun.

Test Plan:
- Reset with GRID_ENTRIES=4, MEM_LAT=2 → loadDefault pulses at cycles 3, 8, 13, 18 after reset release; writeToScreen+writeDefault follow each by 1 cycle. gridCounter sequence is 0,1,2,3, then IDLE at cycle 20.
- Reset asserted asynchronously mid-paint at gridCounter=2 → all outputs 0 within the same cycle; paint restarts from gridCounter=0.
- BEAT_CYCLES=50, NUM_BOXES=3, BOX_PIXELS=2 → one shiftSong per tick. Then 3 loadStartAddress pulses (boxCounter 0,1,2), 6 writeToScreen pulses, each followed 1 cycle later by plot.
- Per-pixel ordering check → loadX, loadY and writeToScreen occur on consecutive cycles; pixelCount is stable from PIX_WAIT to PIX_WR.
- BEAT_CYCLES=8 with a frame longer than 16 cycles → second tick queued, third sets beat_overrun=1. Exactly two frames run back-to-back.
- enable dropped during box 1 → boxes 1..2 finish, then busy=0 and no further shiftSong. Re-raising enable resumes ticks after BEAT_CYCLES.
